// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   state_t     - scanner FSM states
//   KEY_MAP     - hex code per [row][col]
//   lowest_col  - priority encoder, col0 wins
//   row_mask    - active-low one-hot row drive for a row index
package keypad_pkg;

   localparam int ROWS = 4;
   localparam int COLS = 4;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   localparam logic [3:0] KEY_MAP [ROWS][COLS] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   function automatic logic [1:0] lowest_col(input logic [3:0] cols);
      if (cols[0])      return 2'd0;
      else if (cols[1]) return 2'd1;
      else if (cols[2]) return 2'd2;
      else              return 2'd3;
   endfunction

   function automatic logic [3:0] row_mask(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/keypad_stable_counter.sv
// keypad_stable_counter: counts consecutive cycles with level high.
//   clk, reset - clock, synchronous active-high reset
//   clear      - forces the count back to zero
//   level      - signal that must stay high
//   done       - high on the cycle the DEBOUNCE_CYCLES-th consecutive
//                high cycle is seen (count == DEBOUNCE_CYCLES-1, level high)
module keypad_stable_counter #(
   parameter logic [24:0] DEBOUNCE_CYCLES = 25'd300000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic level,
   output logic done
);

   logic [24:0] count;

   assign done = level && !clear && (count == DEBOUNCE_CYCLES - 25'd1);

   // Any low cycle restarts the run; count parks at the terminal value
   // until the owner clears it by leaving the state.
   always_ff @(posedge clk) begin
      if (reset || clear || !level) count <= '0;
      else if (!done)               count <= count + 25'd1;
   end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 keypad and emits one debounced event per press.
//   clk, reset - clock, synchronous active-high reset
//   col_sync   - synchronized columns, 1 = pressed
//   row        - active-low one-hot row drive
//   key_code   - hex code of the last accepted key
//   key_valid  - one-cycle pulse on acceptance
//   key_held   - high from acceptance until release is debounced
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter logic [24:0] SCAN_DIV        = 25'd60000,
   parameter logic [24:0] DEBOUNCE_CYCLES = 25'd300000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] col_sync,
   output logic [3:0] row,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   state_t      state;
   logic [1:0]  row_idx;
   logic [1:0]  cap_col;
   logic [24:0] dwell;
   logic        cap_bit;
   logic        level;
   logic        clear;
   logic        stable;

   assign cap_bit = col_sync[cap_col];
   // One counter serves both debounce directions: press needs the bit high,
   // release needs it low. Held low in states that don't debounce, so every
   // entry to DEBOUNCE/RELEASE starts from zero.
   assign level   = (state == RELEASE) ? ~cap_bit : cap_bit;
   assign clear   = (state == SCAN) || (state == HELD);

   keypad_stable_counter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stable (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .level (level),
      .done  (stable)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SCAN;
         row_idx   <= 2'd0;
         cap_col   <= 2'd0;
         row       <= 4'b1110;
         dwell     <= '0;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         case (state)
            SCAN: begin
               // Columns only mean something once the row has settled
               // through the synchronizer, so look at the terminal count only.
               if (dwell == SCAN_DIV - 25'd1) begin
                  dwell <= '0;
                  if (col_sync == 4'b0000) begin
                     row_idx <= row_idx + 2'd1;
                     row     <= row_mask(row_idx + 2'd1);
                  end else begin
                     cap_col <= lowest_col(col_sync);
                     state   <= DEBOUNCE;
                  end
               end else begin
                  dwell <= dwell + 25'd1;
               end
            end
            DEBOUNCE: begin
               if (!cap_bit) begin
                  state <= SCAN;
                  dwell <= '0;
               end else if (stable) begin
                  state     <= HELD;
                  key_valid <= 1'b1;
                  key_code  <= KEY_MAP[row_idx][cap_col];
                  key_held  <= 1'b1;
               end
            end
            HELD: begin
               if (!cap_bit) state <= RELEASE;
            end
            RELEASE: begin
               if (cap_bit) begin
                  state <= HELD;
               end else if (stable) begin
                  key_held <= 1'b0;
                  row_idx  <= row_idx + 2'd1;
                  row      <= row_mask(row_idx + 2'd1);
                  dwell    <= '0;
                  state    <= SCAN;
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of keypad_scanner with SCAN_DIV=4,
// DEBOUNCE_CYCLES=8. Inputs change and outputs are sampled on the falling
// edge; "cycle n" below means the n-th falling edge after a reference point.
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] col_sync = 4'b0000;
   logic [3:0] row;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   int vec  = 0;
   int errs = 0;

   keypad_scanner #(.SCAN_DIV(25'd4), .DEBOUNCE_CYCLES(25'd8)) dut (
      .clk       (clk),
      .reset     (reset),
      .col_sync  (col_sync),
      .row       (row),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
      $fatal(1);
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_row(input logic [3:0] target);
      int n = 0;
      while (row !== target && n < 32) begin
         step();
         n++;
      end
      vec++;
      if (row !== target) begin
         $display("FAIL wait_row got %b exp %b", row, target);
         errs++;
      end
   endtask

   // Reset state, then 32 idle cycles: each row for 4 cycles, in order.
   task automatic test_reset();
      logic [3:0] e;
      reset = 1'b1;
      step();
      step();
      vec++;
      if (row !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
         $display("FAIL reset_state got row=%b code=%h v=%b h=%b exp 1110 0 0 0",
                  row, key_code, key_valid, key_held);
         errs++;
      end
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (i > 0) step();
         e = ~(4'b0001 << ((i / 4) % 4));
         vec++;
         if (row !== e || key_valid !== 1'b0 || key_code !== 4'h0) begin
            $display("FAIL idle_scan i=%0d got row=%b v=%b code=%h exp row=%b v=0 code=0",
                     i, row, key_valid, key_code, e);
            errs++;
         end
      end
      step();
   endtask

   // Row2/col1 pressed from the first cycle of row 1011. Terminal count is
   // cycle 3, DEBOUNCE entered at cycle 4, key_valid 8 cycles later at 12.
   task automatic test_press();
      wait_row(4'b1011);
      col_sync = 4'b0010;
      for (int n = 0; n <= 19; n++) begin
         if (n > 0) step();
         vec++;
         if (key_valid !== (n == 12) || key_held !== (n >= 12) || row !== 4'b1011 ||
             key_code !== ((n >= 12) ? 4'h8 : 4'h0)) begin
            $display("FAIL press_8 n=%0d got v=%b h=%b row=%b code=%h exp v=%b h=%b row=1011 code=%h",
                     n, key_valid, key_held, row, key_code, (n == 12), (n >= 12),
                     (n >= 12) ? 4'h8 : 4'h0);
            errs++;
         end
      end
   endtask

   // Short dropout during HELD bounces back without a new event. Final
   // release: drop seen at cycle 0, RELEASE from cycle 1, 8 low cycles in
   // RELEASE, so key_held falls and row advances at cycle 9.
   task automatic test_release_glitch();
      for (int n = 0; n <= 6; n++) begin
         if (n > 0) step();
         if (n == 0) col_sync = 4'b0000;
         if (n == 3) col_sync = 4'b0010;
         vec++;
         if (key_valid !== 1'b0 || key_held !== 1'b1 || row !== 4'b1011) begin
            $display("FAIL glitch n=%0d got v=%b h=%b row=%b exp v=0 h=1 row=1011",
                     n, key_valid, key_held, row);
            errs++;
         end
      end
      step();
      col_sync = 4'b0000;
      for (int m = 1; m <= 9; m++) begin
         step();
         vec++;
         if (key_valid !== 1'b0 || key_held !== (m < 9) ||
             row !== ((m < 9) ? 4'b1011 : 4'b0111) || key_code !== 4'h8) begin
            $display("FAIL release m=%0d got v=%b h=%b row=%b code=%h exp v=0 h=%b row=%b code=8",
                     m, key_valid, key_held, row, key_code, (m < 9),
                     (m < 9) ? 4'b1011 : 4'b0111);
            errs++;
         end
      end
   endtask

   // Row0/col3 for 5 cycles: DEBOUNCE at cycle 4, bit low seen at cycle 5,
   // back to SCAN on row0 at cycle 6, row1 at cycle 10.
   task automatic test_short_press();
      wait_row(4'b1110);
      col_sync = 4'b1000;
      for (int n = 0; n <= 10; n++) begin
         if (n > 0) step();
         vec++;
         if (key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h8 ||
             row !== ((n < 10) ? 4'b1110 : 4'b1101)) begin
            $display("FAIL short_press n=%0d got v=%b h=%b code=%h row=%b exp v=0 h=0 code=8 row=%b",
                     n, key_valid, key_held, key_code, row, (n < 10) ? 4'b1110 : 4'b1101);
            errs++;
         end
         if (n == 5) col_sync = 4'b0000;
      end
   endtask

   // 1010 on row3 picks col1 -> code 0. Col3 removed and re-added in HELD.
   task automatic test_multi_key();
      wait_row(4'b0111);
      col_sync = 4'b1010;
      for (int n = 0; n <= 18; n++) begin
         if (n > 0) step();
         vec++;
         if (key_valid !== (n == 12) || key_held !== (n >= 12) || row !== 4'b0111 ||
             key_code !== ((n >= 12) ? 4'h0 : 4'h8)) begin
            $display("FAIL multi_key n=%0d got v=%b h=%b row=%b code=%h exp v=%b h=%b row=0111 code=%h",
                     n, key_valid, key_held, row, key_code, (n == 12), (n >= 12),
                     (n >= 12) ? 4'h0 : 4'h8);
            errs++;
         end
         if (n == 13) col_sync = 4'b0010;
         if (n == 15) col_sync = 4'b1010;
      end
   endtask

   // Reset from HELD, mid-DEBOUNCE, then mid-HELD of a nonzero key.
   task automatic test_reset_mid();
      col_sync = 4'b0000;
      reset = 1'b1;
      step();
      reset = 1'b0;
      col_sync = 4'b0001;
      for (int n = 0; n <= 7; n++) begin
         if (n > 0) step();
         vec++;
         if (key_valid !== 1'b0 || row !== 4'b1110) begin
            $display("FAIL pre_debounce n=%0d got v=%b row=%b exp v=0 row=1110", n, key_valid, row);
            errs++;
         end
      end
      reset = 1'b1;
      step();
      vec++;
      if (row !== 4'b1110 || key_held !== 1'b0 || key_valid !== 1'b0 || key_code !== 4'h0) begin
         $display("FAIL reset_debounce got row=%b h=%b v=%b code=%h exp 1110 0 0 0",
                  row, key_held, key_valid, key_code);
         errs++;
      end
      reset = 1'b0;
      // Key stays down: re-detected from scratch, valid at cycle 20.
      for (int n = 9; n <= 23; n++) begin
         step();
         vec++;
         if (key_valid !== (n == 20) || key_held !== (n >= 20) || row !== 4'b1110 ||
             key_code !== ((n >= 20) ? 4'h1 : 4'h0)) begin
            $display("FAIL rescan n=%0d got v=%b h=%b row=%b code=%h exp v=%b h=%b row=1110 code=%h",
                     n, key_valid, key_held, row, key_code, (n == 20), (n >= 20),
                     (n >= 20) ? 4'h1 : 4'h0);
            errs++;
         end
      end
      reset = 1'b1;
      step();
      vec++;
      if (row !== 4'b1110 || key_held !== 1'b0 || key_valid !== 1'b0 || key_code !== 4'h0) begin
         $display("FAIL reset_held got row=%b h=%b v=%b code=%h exp 1110 0 0 0",
                  row, key_held, key_valid, key_code);
         errs++;
      end
      reset = 1'b0;
      col_sync = 4'b0000;
      for (int n = 25; n <= 28; n++) begin
         step();
         vec++;
         if (key_valid !== 1'b0 || key_held !== 1'b0 || row !== ((n < 28) ? 4'b1110 : 4'b1101)) begin
            $display("FAIL post_reset n=%0d got v=%b h=%b row=%b exp v=0 h=0 row=%b",
                     n, key_valid, key_held, row, (n < 28) ? 4'b1110 : 4'b1101);
            errs++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_press();
      test_release_glitch();
      test_short_press();
      test_multi_key();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
